// File: rtl/flush_ctrl_if.sv
// flush_ctrl_if: flush request / redirect / maintenance handshake bundle.
// master = pipeline and cache side, slave = flush controller.
interface flush_ctrl_if #(
   parameter int NUM_SRC = 8,
   parameter int PC_W    = 32
);
   logic [NUM_SRC-1:0]      flush_req;
   logic [NUM_SRC*PC_W-1:0] flush_pc;
   logic [NUM_SRC-1:0]      flush_out;
   logic                    redirect_valid;
   logic [PC_W-1:0]         redirect_pc;
   logic                    front_hold;
   logic                    maint_req;
   logic                    maint_ack;
   logic                    busy;
   logic [NUM_SRC*32-1:0]   perf_cnt;

   modport master (
      output flush_req, flush_pc, maint_ack,
      input  flush_out, redirect_valid, redirect_pc, front_hold,
             maint_req, busy, perf_cnt
   );

   modport slave (
      input  flush_req, flush_pc, maint_ack,
      output flush_out, redirect_valid, redirect_pc, front_hold,
             maint_req, busy, perf_cnt
   );
endinterface

// File: rtl/flush_ctrl.sv
// flush_ctrl: pipeline flush/redirect controller.
// Oldest requesting stage (highest index) wins; a single redirect is
// registered to fetch. Sources marked in SYNC_MASK first run a maintenance
// req/ack handshake with the caches/tlb while the front end is held.
// Optional: define FLUSH_PERF_CNT_EN for per-source saturating win counters.
module flush_ctrl #(
   parameter int                 NUM_SRC   = 8,
   parameter int                 PC_W      = 32,
   parameter logic [NUM_SRC-1:0] SYNC_MASK = 8'b0001_0000
) (
   input  logic        clk,
   input  logic        rstn,
   flush_ctrl_if.slave bus
);
   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_ACK, REDIR} state_t;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  win_idx, win_idx_nxt;
   logic [PC_W-1:0]   win_pc, win_pc_nxt;
   logic [IDX_W-1:0]  hi_idx;
   logic [PC_W-1:0]   hi_pc;
   logic              any_req;
   logic              capture;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              maint_req;
   logic              front_hold;

   // Thermometer flush: boundary k flushes if any stage at or older than k asks
   always_comb begin : flush_therm
      logic acc;
      acc           = 1'b0;
      bus.flush_out = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         acc = acc | bus.flush_req[k];
         bus.flush_out[k] = acc;
      end
   end

   // Priority pick: highest set request index is the oldest stage
   always_comb begin
      hi_idx = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (bus.flush_req[i]) hi_idx = IDX_W'(i);
   end

   assign any_req = |bus.flush_req;
   assign hi_pc   = bus.flush_pc[int'(hi_idx)*PC_W +: PC_W];

   // Next state and winner capture
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         WAIT_ACK: begin
            if (any_req && (hi_idx > win_idx)) begin
               // An older stage takes over. Without an ack the in-flight
               // maintenance still has to finish; with an ack it is done,
               // so the new winner decides whether another round is needed.
               capture   = 1'b1;
               state_nxt = (bus.maint_ack && !SYNC_MASK[hi_idx]) ? REDIR : WAIT_ACK;
            end else if (bus.maint_ack) begin
               state_nxt = REDIR;
            end
         end
         default: begin
            // IDLE and REDIR treat a new request identically
            state_nxt = IDLE;
            if (any_req) begin
               capture   = 1'b1;
               state_nxt = SYNC_MASK[hi_idx] ? WAIT_ACK : REDIR;
            end
         end
      endcase
      win_idx_nxt = capture ? hi_idx : win_idx;
      win_pc_nxt  = capture ? hi_pc  : win_pc;
   end

   // State, winner and registered outputs (all follow the next state)
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         win_idx        <= '0;
         win_pc         <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         maint_req      <= 1'b0;
         front_hold     <= 1'b0;
      end else begin
         state          <= state_nxt;
         win_idx        <= win_idx_nxt;
         win_pc         <= win_pc_nxt;
         redirect_valid <= (state_nxt == REDIR);
         if (state_nxt == REDIR) redirect_pc <= win_pc_nxt;
         maint_req      <= (state_nxt == WAIT_ACK);
         front_hold     <= (state_nxt == WAIT_ACK);
      end
   end

   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = redirect_pc;
   assign bus.maint_req      = maint_req;
   assign bus.front_hold     = front_hold;
   assign bus.busy           = (state != IDLE);

`ifdef FLUSH_PERF_CNT_EN
   logic [31:0] win_cnt [NUM_SRC];

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
      // Count captures of source k as winner, sticking at all-ones
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn)
            win_cnt[k] <= '0;
         else if (capture && (hi_idx == IDX_W'(k)) && (win_cnt[k] != 32'hFFFF_FFFF))
            win_cnt[k] <= win_cnt[k] + 32'd1;
      end
      assign bus.perf_cnt[k*32 +: 32] = win_cnt[k];
   end
`else
   assign bus.perf_cnt = '0;
`endif

endmodule

// File: doc/flush_ctrl.md
Name: flush_ctrl

Overview:
- Parametrised pipeline flush/redirect controller; successor to the fixed-stage flush priority unit.
- Takes per-stage flush requests with redirect PCs and produces a thermometer flush vector to every pipeline boundary, where the oldest requester wins.
- Registers a single redirect to fetch.
- For sources flagged as needing maintenance (priv/ibar/tlb ops), runs a req/ack handshake with icache/dcache/tlb and holds the front end until done.

Parameters:
- NUM_SRC, 8, number of flush sources/pipeline boundaries; index 0 = youngest (if1), NUM_SRC-1 = oldest (wb).
- PC_W, 32, redirect PC width.
- SYNC_MASK, 8'b0001_0000, per-source bit: 1 = that source's flush requires the maintenance handshake before redirect.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush_req  in  NUM_SRC  per-source flush request, level, sampled every cycle
- flush_pc  in  NUM_SRC*PC_W  redirect target per source; slice k = bits [k*PC_W +: PC_W]
- flush_out  out  NUM_SRC  combinational; bit k = OR of flush_req[NUM_SRC-1:k]
- redirect_valid  out  1  one-cycle redirect pulse to fetch
- redirect_pc  out  PC_W  valid while redirect_valid
- front_hold  out  1  stall fetch/icache while maintenance is pending
- maint_req  out  1  maintenance request to caches/tlb
- maint_ack  in  1  maintenance complete, one-cycle pulse
- busy  out  1  state != IDLE
- perf_cnt  out  NUM_SRC*32  per-source win counters (see Optional Feature)

Behaviour:
- Reset (rstn low, async): state=IDLE; win_idx=0; win_pc=0; redirect_valid=0; redirect_pc=0; maint_req=0; front_hold=0; busy=0; perf_cnt=0.
- flush_out is purely combinational (zero latency) and never gated by state.
- Winner: highest set index of flush_req (oldest stage). Its PC is captured on the clock edge.
- FSM states: IDLE, WAIT_ACK, REDIR.
  - IDLE, any flush_req: capture win_idx/win_pc. If SYNC_MASK[win_idx], go to WAIT_ACK; else go to REDIR.
  - WAIT_ACK: maint_req=1 and front_hold=1, both registered and asserted the cycle after entry. A flush_req with index > win_idx recaptures win_idx/win_pc and stays in WAIT_ACK. Requests with index <= win_idx are ignored. On maint_ack, go to REDIR; maint_req drops the same edge.
  - REDIR: redirect_valid=1 and redirect_pc=win_pc for exactly one cycle; front_hold=0. A flush_req in REDIR is processed exactly as in IDLE (new capture, next state chosen from it). The current redirect pulse is still emitted, and the later redirect supersedes it.
- Redirect latency:
  - Non-sync flush: request at cycle N gives redirect_valid at N+1.
  - Sync flush: redirect_valid the cycle after maint_ack.
- maint_ack outside WAIT_ACK is ignored.
- Simultaneous maint_ack and an older flush_req in WAIT_ACK: the older request wins. Recapture it; if it is a sync source, remain in WAIT_ACK and reissue; else go to REDIR with the new PC.
- Reset mid-handshake: maint_req drops immediately. Caches must tolerate an abandoned request.

Optional Feature:
- Macro: FLUSH_PERF_CNT_EN.
- Defined: perf_cnt slice k increments by 1 each time source k is captured as winner; saturates at 32'hFFFF_FFFF; cleared by reset.
- Undefined: no counter registers; perf_cnt tied to 0.

Test Plan:
- NUM_SRC=8, SYNC_MASK=8'h10. flush_req=8'b0000_0110, pc[2]=32'h1C00_0100 -> flush_out=8'b0000_0111 same cycle; next cycle redirect_valid=1, redirect_pc=32'h1C00_0100; then IDLE.
- flush_req=8'b1001_0001, pc[7]=32'h8000_0000 -> flush_out=8'hFF; redirect_pc=32'h8000_0000 (oldest wins, no handshake).
- flush_req[4] pulse, pc[4]=32'h1C00_2000 -> maint_req=1 and front_hold=1 from the next cycle; maint_ack after 5 cycles -> maint_req=0; redirect_valid=1 with 32'h1C00_2000 one cycle later.
- In WAIT_ACK (win=4), flush_req[6] with pc=32'h1C00_3000 -> win_idx=6 and redirect goes to 32'h1C00_3000 after ack. flush_req[1] in WAIT_ACK -> ignored.
- Assert rstn=0 mid-WAIT_ACK -> maint_req, front_hold, busy go 0 immediately; stray maint_ack after reset -> no redirect.
- With FLUSH_PERF_CNT_EN: three flushes won by source 2 and one by source 4 -> perf_cnt[2]=3, perf_cnt[4]=1, all other slices 0.
